rect_fill_ctrl: RTL

- Parametrised successor to the lab2 screen-clear state machine; integrates the x/y counters and their control into one block.
- Fills or outlines an arbitrary clipped rectangle on the VGA adapter framebuffer, one pixel per clock.
- Uses a start/busy/done handshake; drives the adapter's x, y, colour and plot inputs directly.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/xy_scan_counter.sv | 43 ++++
 rtl/rect_fill_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for blocks that drive the VGA adapter framebuffer.
package vga_pkg;

    localparam int DEF_XW       = 8;
    localparam int DEF_YW       = 7;
    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;
    localparam int DEF_CW       = 3;

    typedef enum logic {
        FILL_SOLID   = 1'b0,
        FILL_OUTLINE = 1'b1
    } fill_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SCAN,
        ST_DONE
    } fill_state_e;

    function automatic int clamp_max(input int v, input int hi);
        return (v > hi) ? hi : v;
    endfunction

endpackage

// File: rtl/xy_scan_counter.sv
// Raster-order x/y position counter with init, step and row-wrap, plus
// last-column / last-row flags.
module xy_scan_counter #(
    parameter int XW = 8,
    parameter int YW = 7
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          init,
    input  logic          step,
    input  logic [XW-1:0] x_first,
    input  logic [YW-1:0] y_first,
    input  logic [XW-1:0] x_last,
    input  logic [YW-1:0] y_last,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          x_end,
    output logic          y_end
);

    assign x_end = (x == x_last);
    assign y_end = (y == y_last);

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            x <= '0;
            y <= '0;
        end else if (init) begin
            x <= x_first;
            y <= y_first;
        end else if (step) begin
            if (!x_end) begin
                x <= x + 1'b1;
            end else if (!y_end) begin
                x <= x_first;
                y <= y + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rect_fill_ctrl.sv
// Fills or outlines a clipped rectangle on the VGA framebuffer, one pixel per
// clock, behind a start/busy/done handshake.
module rect_fill_ctrl
    import vga_pkg::*;
#(
    parameter int XW       = DEF_XW,
    parameter int YW       = DEF_YW,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int CW       = DEF_CW
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          start,
    input  logic          mode,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y0,
    input  logic [YW-1:0] y1,
    input  logic [CW-1:0] colour_in,
    output logic          busy,
    output logic          done,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour,
    output logic          plot
);

    fill_state_e   state;
    fill_mode_e    mode_q;
    logic [XW-1:0] bx0, bx1, cx1;
    logic [YW-1:0] by0, by1, cy1;
    logic          empty, x_end, y_end, last_pixel, on_border;
    logic          scan_init, scan_step;

    // Only the far edges need clipping; an off-screen near edge makes the
    // rectangle empty instead.
    assign cx1   = XW'(clamp_max(int'(bx1), SCREEN_W - 1));
    assign cy1   = YW'(clamp_max(int'(by1), SCREEN_H - 1));
    assign empty = (int'(bx0) >= SCREEN_W) || (int'(by0) >= SCREEN_H)
                || (bx0 > cx1) || (by0 > cy1);

    assign scan_init  = (state == ST_LOAD) && !empty;
    assign last_pixel = x_end && y_end;
    assign scan_step  = (state == ST_SCAN) && !last_pixel;

    xy_scan_counter #(
        .XW (XW),
        .YW (YW)
    ) u_scan (
        .clk     (clk),
        .resetb  (resetb),
        .init    (scan_init),
        .step    (scan_step),
        .x_first (bx0),
        .y_first (by0),
        .x_last  (cx1),
        .y_last  (cy1),
        .x       (x),
        .y       (y),
        .x_end   (x_end),
        .y_end   (y_end)
    );

    // Outline mode still walks every interior pixel; it only masks the strobe.
    assign on_border = (x == bx0) || x_end || (y == by0) || y_end;
    assign plot      = (state == ST_SCAN) && ((mode_q == FILL_SOLID) || on_border);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            mode_q <= FILL_SOLID;
            bx0    <= '0;
            bx1    <= '0;
            by0    <= '0;
            by1    <= '0;
            colour <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bx0    <= x0;
                        bx1    <= x1;
                        by0    <= y0;
                        by1    <= y1;
                        mode_q <= fill_mode_e'(mode);
                        colour <= colour_in;
                        busy   <= 1'b1;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (empty) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (last_pixel) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
